// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: autozero, fixed-time integrate of VIN, then
// deintegrate against the opposite-polarity reference while counting until
// the comparator flips. Holds count, sign and overrange until the next
// conversion ends.
module dual_slope_ctrl #(
  parameter int unsigned AZ_CYCLES  = 64,
  parameter int unsigned INT_CYCLES = 1000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEINT_MAX  = 2000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             comp_i,
  input  logic             sat_hi_i,
  input  logic             sat_lo_i,
  input  logic             ref_ok_i,
  output logic [3:0]       afe_sel_o,
  output logic             afe_reset_o,
  output logic             ref_sign_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic             sign_o,
  output logic             overrange_o
);

  localparam int unsigned PH_MAX = (AZ_CYCLES > INT_CYCLES) ? AZ_CYCLES : INT_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;
  localparam logic [PH_W-1:0]  AZ_LAST   = PH_W'(AZ_CYCLES - 1);
  localparam logic [PH_W-1:0]  INT_LAST  = PH_W'(INT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEINT_LIM = CNT_W'(DEINT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RST,
    AZ,
    INTEG,
    DEINT,
    DONE
  } state_t;

  state_t           state_q, state_n;
  logic [PH_W-1:0]  ph_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pol_q;
  logic             pol_ld;
  logic             ovr_n;

  logic [3:0] meta_q, sync_q;
  logic       comp_s, sat_s, ref_ok_s;

  // Two-flop synchronizers for the asynchronous analog status lines
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {ref_ok_i, sat_lo_i, sat_hi_i, comp_i};
      sync_q <= meta_q;
    end
  end

  assign comp_s   = sync_q[0];
  assign sat_s    = sync_q[1] | sync_q[2];
  assign ref_ok_s = sync_q[3];

  // Next-state logic, polarity-latch strobe and overrange flag for DONE entry
  always_comb begin
    state_n = state_q;
    pol_ld  = 1'b0;
    ovr_n   = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_n = RST;
      RST:   state_n = AZ;
      AZ:    if ((ph_q >= AZ_LAST) && ref_ok_s) state_n = INTEG;
      INTEG: begin
        if (sat_s) begin
          state_n = DONE;
          ovr_n   = 1'b1;
        end else if (ph_q == INT_LAST) begin
          state_n = DEINT;
          pol_ld  = 1'b1;
        end
      end
      DEINT: begin
        if (sat_s) begin
          state_n = DONE;
          ovr_n   = 1'b1;
        end else if (comp_s != pol_q) begin
          state_n = DONE;
        end else if (cnt_q == DEINT_LIM) begin
          state_n = DONE;
          ovr_n   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, phase timer (saturating so an extended autozero cannot wrap)
  // and deintegrate counter (zero outside DEINT, so an INTEG abort reports 0)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      if (state_n != state_q)
        ph_q <= '0;
      else if (ph_q != '1)
        ph_q <= ph_q + PH_W'(1);
      if ((state_q == DEINT) && (state_n == DEINT))
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;
    end
  end

  // Reference polarity and held result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pol_q       <= 1'b0;
      count_o     <= '0;
      sign_o      <= 1'b0;
      overrange_o <= 1'b0;
    end else begin
      if (pol_ld)
        pol_q <= comp_s;
      if ((state_n == DONE) && (state_q != DONE)) begin
        count_o     <= cnt_q;
        sign_o      <= pol_q;
        overrange_o <= ovr_n;
      end
    end
  end

  // Phase select decoded from registered state and polarity
  always_comb begin
    afe_sel_o = '0;
    case (state_q)
      AZ:      afe_sel_o = 4'b0001;
      INTEG:   afe_sel_o = 4'b0010;
      DEINT:   afe_sel_o = pol_q ? 4'b1000 : 4'b0100;
      default: afe_sel_o = '0;
    endcase
  end

  // pol_q only changes when entering DEINT, so it doubles as the held reference sign
  assign ref_sign_o  = pol_q;
  assign afe_reset_o = (state_q == RST);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: doc/dual_slope_ctrl.md
DUAL_SLOPE_CTRL -- requirements
Module: dual_slope_ctrl

Interface
REQ-001 Parameters: AZ_CYCLES, default 64, autozero phase length in clk_i cycles (>=1).
REQ-002 Parameters: INT_CYCLES, default 1000, fixed integrate (VIN) phase length in clk_i cycles (>=1).
REQ-003 Parameters: CNT_W, default 16, width of the deintegrate counter and result.
REQ-004 Parameters: DEINT_MAX, default 2000, deintegrate overrange limit (< 2**CNT_W).
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 Ports, clock and reset first: clk_i, in, 1, system clock.
REQ-007 Ports: rst_i, in, 1, synchronous active-high reset.
REQ-008 Ports: start_i, in, 1, conversion request, sampled in IDLE only.
REQ-009 Ports: comp_i, sat_hi_i, sat_lo_i, ref_ok_i, in, 1 each, asynchronous analog status.
REQ-010 Ports: afe_sel_o, out, 4, one-hot phase select: bit0 AZ, bit1 VIN, bit2 +VREF, bit3 -VREF.
REQ-011 Ports: afe_reset_o, out, 1, integrator discharge.
REQ-012 Ports: ref_sign_o, out, 1, 0 = +VREF, 1 = -VREF.
REQ-013 Ports: busy_o, out, 1; done_o, out, 1, one-cycle pulse.
REQ-014 Ports: count_o, out, CNT_W; sign_o, out, 1; overrange_o, out, 1; held result.

Function
REQ-015 Each of comp_i, sat_hi_i, sat_lo_i and ref_ok_i SHALL pass through its own 2-flop synchronizer; all FSM decisions use the synchronized versions (comp_s, sat_s = sat_hi_s | sat_lo_s, ref_ok_s).
REQ-016 States SHALL be IDLE, RST, AZ, INTEG, DEINT, DONE.
REQ-017 IDLE: afe_sel_o = 0000, busy_o = 0; start_i = 1 -> RST next cycle.
REQ-018 RST: lasts exactly 1 cycle with afe_reset_o = 1 and afe_sel_o = 0000, then AZ.
REQ-019 AZ: afe_sel_o = 0001; lasts AZ_CYCLES cycles, extended while ref_ok_s = 0; exits to INTEG on the first cycle with phase count >= AZ_CYCLES and ref_ok_s = 1.
REQ-020 INTEG: afe_sel_o = 0010 for exactly INT_CYCLES cycles.
REQ-021 On the last INTEG cycle, pol SHALL be latched as comp_s.
REQ-022 In DEINT, ref_sign_o = pol.
REQ-023 In DEINT, afe_sel_o = 0100 if pol = 0, else 1000.
REQ-024 Outside DEINT, ref_sign_o SHALL hold its last value.
REQ-025 DEINT counter SHALL clear on entry and be evaluated each DEINT cycle in this priority: sat_s = 1 -> DONE, overrange; comp_s != pol -> DONE, normal; counter == DEINT_MAX -> DONE, overrange; else counter + 1.
REQ-026 sat_s = 1 during INTEG SHALL go to DONE with overrange = 1 and count = 0.
REQ-027 On entry to DONE, count_o SHALL take the counter value, sign_o SHALL take pol, and overrange_o SHALL take the flag.
REQ-028 count_o, sign_o and overrange_o SHALL be held until the next DONE.
REQ-029 DONE: 1 cycle, done_o = 1, afe_sel_o = 0000, then IDLE.
REQ-030 busy_o = 1 in all states except IDLE.
REQ-031 start_i SHALL be ignored outside IDLE, with no queuing.
REQ-032 afe_sel_o SHALL never have more than one bit set, on any cycle.
REQ-033 All outputs SHALL be registered or decoded from registered state only.

Reset
REQ-034 While rst_i = 1 at a clock edge, FSM -> IDLE and counters cleared.
REQ-035 Reset values: afe_sel_o = 0000, afe_reset_o = 0, ref_sign_o = 0, busy_o = 0, done_o = 0, count_o = 0, sign_o = 0, overrange_o = 0.
REQ-036 Synchronizer flops SHALL clear to 0 on reset.
REQ-037 rst_i asserted mid-conversion SHALL abort within one cycle with no done_o pulse.

Verification (AZ_CYCLES=4, INT_CYCLES=8, DEINT_MAX=20, CNT_W=8)
REQ-038 Directed scenario 1: ref_ok_i = 1, comp_i = 1, then a start_i pulse; drive comp_i = 0 at DEINT cycle 10 -> the phase sequence is RST 1 cycle, AZ 4, INTEG 8; DEINT uses afe_sel_o = 1000 and ref_sign_o = 1; then count_o = 12 (10 + 2 synchronizer cycles), sign_o = 1, overrange_o = 0, and done_o is high for 1 cycle.
REQ-039 Directed scenario 2: comp_i = 0 at the INTEG end, and it never flips -> overrange_o = 1, count_o = 20, afe_sel_o = 0100 during DEINT.
REQ-040 Directed scenario 3: ref_ok_i = 0 until 6 cycles into AZ -> AZ lasts 8 cycles (6 plus 2 synchronizer cycles), then INTEG proceeds normally.
REQ-041 Directed scenario 4: sat_hi_i pulsed high for 3 cycles at INTEG cycle 3 -> DONE follows with overrange_o = 1, count_o = 0, and no DEINT phase.
REQ-042 Directed scenario 5: rst_i asserted during DEINT -> next cycle all outputs at reset values, no done_o; a subsequent start_i runs a full conversion.
REQ-043 Directed scenario 6: start_i held high continuously -> back-to-back conversions, each separated by exactly one IDLE cycle, and afe_sel_o one-hot or zero on every cycle.
